// File: rtl/acs_path_metric_pkg.sv
// ============================================================================
//  Package  : viterbi_pkg
//  Brief    : Shared trellis constants, predecessor helper and ACS FSM states
//             for the 4-state (K=3, 7/5) Viterbi decoder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    localparam int NUM_STATES   = 4;
    localparam int DEF_PM_WIDTH = 6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_state_t;

    // Predecessor j (0/1) of next state k in the shift-register trellis.
    function automatic logic [1:0] pred(input logic [1:0] k, input logic j);
        return {k[0], j};
    endfunction

endpackage

`default_nettype wire

// File: rtl/acs_path_metric_acs_unit.sv
// ============================================================================
//  Module   : acs_unit
//  Brief    : One add-compare-select cell: two candidate sums, compare,
//             select the survivor and emit its decision bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module acs_unit #(
    parameter int PM_WIDTH = 6
) (
    input  logic [PM_WIDTH-1:0] pm_lo,
    input  logic [PM_WIDTH-1:0] pm_hi,
    input  logic [3:0]          node,
    output logic [PM_WIDTH:0]   pm_sum,
    output logic                decision
);

    logic [PM_WIDTH:0] w_sum_lo;
    logic [PM_WIDTH:0] w_sum_hi;

    // One guard bit so the sum never wraps ahead of normalisation.
    assign w_sum_lo = {1'b0, pm_lo} + {{(PM_WIDTH-1){1'b0}}, node[1:0]};
    assign w_sum_hi = {1'b0, pm_hi} + {{(PM_WIDTH-1){1'b0}}, node[3:2]};

    // Strict compare: a tie keeps the lower predecessor.
    assign decision = (w_sum_hi < w_sum_lo);
    assign pm_sum   = decision ? w_sum_hi : w_sum_lo;

endmodule

`default_nettype wire

// File: rtl/acs_path_metric.sv
// ============================================================================
//  Module   : acs_path_metric
//  Brief    : ACS stage: four path metrics, survivor decisions, MSB-clear
//             normalisation, frame counter and best end-state report.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module acs_path_metric
    import viterbi_pkg::*;
#(
    parameter int PM_WIDTH  = DEF_PM_WIDTH,
    parameter int FRAME_LEN = 64,
    parameter int INIT_PM   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st,
    input  logic                in_valid,
    input  logic [3:0]          node0,
    input  logic [3:0]          node1,
    input  logic [3:0]          node2,
    input  logic [3:0]          node3,
    output logic [PM_WIDTH-1:0] pm0,
    output logic [PM_WIDTH-1:0] pm1,
    output logic [PM_WIDTH-1:0] pm2,
    output logic [PM_WIDTH-1:0] pm3,
    output logic [3:0]          decision,
    output logic                dec_valid,
    output logic [1:0]          best_state,
    output logic                done
);

    localparam int                CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(FRAME_LEN - 1);
    localparam logic [PM_WIDTH-1:0] c_init = PM_WIDTH'(INIT_PM);
    localparam logic [PM_WIDTH:0] c_half = (PM_WIDTH+1)'(1) << (PM_WIDTH - 1);

    fsm_state_t          r_state;
    fsm_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [PM_WIDTH-1:0] r_pm [NUM_STATES];
    logic [3:0]          r_decision;
    logic                r_dec_valid;
    logic [1:0]          r_best;
    logic                r_done;

    logic [3:0]          w_node [NUM_STATES];
    logic [PM_WIDTH:0]   w_sum  [NUM_STATES];
    logic [PM_WIDTH-1:0] w_new  [NUM_STATES];
    logic [3:0]          w_dec;
    logic                w_all_high;
    logic [1:0]          w_best;
    logic [PM_WIDTH-1:0] w_best_pm;
    logic                w_restart;
    logic                w_accept;
    logic                w_final;

    assign w_node[0] = node0;
    assign w_node[1] = node1;
    assign w_node[2] = node2;
    assign w_node[3] = node3;

    for (genvar k = 0; k < NUM_STATES; k++) begin : g_acs
        acs_unit #(
            .PM_WIDTH (PM_WIDTH)
        ) u_acs (
            .pm_lo    (r_pm[pred(2'(k), 1'b0)]),
            .pm_hi    (r_pm[pred(2'(k), 1'b1)]),
            .node     (w_node[k]),
            .pm_sum   (w_sum[k]),
            .decision (w_dec[k])
        );
    end

    // Clearing the MSB of every metric subtracts half-range uniformly.
    always_comb begin
        w_all_high = 1'b1;
        for (int k = 0; k < NUM_STATES; k++) begin
            if (w_sum[k] < c_half) w_all_high = 1'b0;
        end
        for (int k = 0; k < NUM_STATES; k++) begin
            w_new[k] = {w_sum[k][PM_WIDTH-1] & ~w_all_high, w_sum[k][PM_WIDTH-2:0]};
        end
    end

    always_comb begin
        w_best    = 2'd0;
        w_best_pm = w_new[0];
        for (int k = 1; k < NUM_STATES; k++) begin
            if (w_new[k] < w_best_pm) begin
                w_best_pm = w_new[k];
                w_best    = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (st) w_state_nxt = S_RUN;
            S_RUN:   if (!st && in_valid && (r_count == c_last)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A start pulse always wins over a coincident symbol.
    always_comb begin
        w_restart = st;
        w_accept  = (r_state == S_RUN) && in_valid && !st;
        w_final   = w_accept && (r_count == c_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STATES; k++) r_pm[k] <= '0;
            r_count     <= '0;
            r_decision  <= '0;
            r_dec_valid <= 1'b0;
            r_best      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_dec_valid <= w_accept;
            r_done      <= w_final;
            if (w_restart) begin
                r_pm[0] <= '0;
                for (int k = 1; k < NUM_STATES; k++) r_pm[k] <= c_init;
                r_count <= '0;
            end else if (w_accept) begin
                for (int k = 0; k < NUM_STATES; k++) r_pm[k] <= w_new[k];
                r_decision <= w_dec;
                r_count    <= w_final ? '0 : r_count + CNT_W'(1);
                if (w_final) r_best <= w_best;
            end
        end
    end

    assign pm0        = r_pm[0];
    assign pm1        = r_pm[1];
    assign pm2        = r_pm[2];
    assign pm3        = r_pm[3];
    assign decision   = r_decision;
    assign dec_valid  = r_dec_valid;
    assign best_state = r_best;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_acs_path_metric.sv
// ============================================================================
//  Module   : tb_acs_path_metric
//  Brief    : Scoreboard bench: a narrow long-frame instance (A) and a default
//             width short-frame instance (B) share stimulus against a model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_acs_path_metric;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [1:0]       best;
        logic [3:0]       dec;
        logic [3:0][31:0] pm;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       st;
    logic       in_valid;
    logic [3:0] n0, n1, n2, n3;

    logic [4:0] a_pm0, a_pm1, a_pm2, a_pm3;
    logic [3:0] a_dec;
    logic       a_dv, a_done;
    logic [1:0] a_best;
    logic [5:0] b_pm0, b_pm1, b_pm2, b_pm3;
    logic [3:0] b_dec;
    logic       b_dv, b_done;
    logic [1:0] b_best;

    int c_half [2] = '{16, 32};
    int c_flen [2] = '{1024, 4};
    int c_init     = 8;

    int         mref [2][4];
    int         moff [2];
    bit         mrun [2];
    int         mcnt [2];
    logic [3:0] mdec [2];
    logic [1:0] mbest[2];

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_err    = 0;

    acs_path_metric #(.PM_WIDTH(5), .FRAME_LEN(1024), .INIT_PM(8)) dut_a (
        .clk(clk), .rst(rst), .st(st), .in_valid(in_valid),
        .node0(n0), .node1(n1), .node2(n2), .node3(n3),
        .pm0(a_pm0), .pm1(a_pm1), .pm2(a_pm2), .pm3(a_pm3),
        .decision(a_dec), .dec_valid(a_dv), .best_state(a_best), .done(a_done)
    );

    acs_path_metric #(.PM_WIDTH(6), .FRAME_LEN(4), .INIT_PM(8)) dut_b (
        .clk(clk), .rst(rst), .st(st), .in_valid(in_valid),
        .node0(n0), .node1(n1), .node2(n2), .node3(n3),
        .pm0(b_pm0), .pm1(b_pm1), .pm2(b_pm2), .pm3(b_pm3),
        .decision(b_dec), .dec_valid(b_dv), .best_state(b_best), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset(input int i);
        mrun[i] = 1'b0;
        moff[i] = 0;
        mcnt[i] = 0;
        mdec[i] = '0;
        mbest[i] = '0;
        for (int k = 0; k < 4; k++) mref[i][k] = 0;
    endtask

    // Unbounded reference metrics; the expected DUT value is ref - half*offset.
    task automatic model_step(input int i, output exp_t e);
        logic [3:0] nv [4];
        int nr [4];
        int a, b, bi;
        bit high;
        nv[0] = n0; nv[1] = n1; nv[2] = n2; nv[3] = n3;
        e = '0;
        if (st) begin
            mrun[i] = 1'b1;
            mref[i][0] = 0;
            for (int k = 1; k < 4; k++) mref[i][k] = c_init;
            moff[i] = 0;
            mcnt[i] = 0;
        end else if (mrun[i] && in_valid) begin
            for (int k = 0; k < 4; k++) begin
                a = mref[i][(k % 2) * 2]     + int'(nv[k][1:0]);
                b = mref[i][(k % 2) * 2 + 1] + int'(nv[k][3:2]);
                nr[k] = (b < a) ? b : a;
                mdec[i][k] = (b < a);
            end
            high = 1'b1;
            for (int k = 0; k < 4; k++) begin
                mref[i][k] = nr[k];
                if (nr[k] - c_half[i] * moff[i] < c_half[i]) high = 1'b0;
            end
            if (high) moff[i]++;
            mcnt[i]++;
            e.valid = 1'b1;
            if (mcnt[i] == c_flen[i]) begin
                bi = 0;
                for (int k = 1; k < 4; k++) if (mref[i][k] < mref[i][bi]) bi = k;
                mbest[i] = 2'(bi);
                e.done   = 1'b1;
                mrun[i]  = 1'b0;
                mcnt[i]  = 0;
            end
        end
        for (int k = 0; k < 4; k++) e.pm[k] = 32'(mref[i][k] - c_half[i] * moff[i]);
        e.dec  = mdec[i];
        e.best = mbest[i];
    endtask

    task automatic compare_a();
        exp_t e;
        e = q_a.pop_front();
        chk("A.dec_valid", 32'(a_dv), 32'(e.valid));
        chk("A.done", 32'(a_done), 32'(e.done));
        chk("A.pm0", 32'(a_pm0), e.pm[0]);
        chk("A.pm1", 32'(a_pm1), e.pm[1]);
        chk("A.pm2", 32'(a_pm2), e.pm[2]);
        chk("A.pm3", 32'(a_pm3), e.pm[3]);
        chk("A.decision", 32'(a_dec), 32'(e.dec));
        if (e.done) chk("A.best_state", 32'(a_best), 32'(e.best));
    endtask

    task automatic compare_b();
        exp_t e;
        e = q_b.pop_front();
        chk("B.dec_valid", 32'(b_dv), 32'(e.valid));
        chk("B.done", 32'(b_done), 32'(e.done));
        chk("B.pm0", 32'(b_pm0), e.pm[0]);
        chk("B.pm1", 32'(b_pm1), e.pm[1]);
        chk("B.pm2", 32'(b_pm2), e.pm[2]);
        chk("B.pm3", 32'(b_pm3), e.pm[3]);
        chk("B.decision", 32'(b_dec), 32'(e.dec));
        if (e.done) chk("B.best_state", 32'(b_best), 32'(e.best));
    endtask

    // Called at a falling edge: drive, predict, clock once, check.
    task automatic step(input bit s, input bit v, input logic [3:0] a0, a1, a2, a3);
        exp_t e;
        st = s; in_valid = v; n0 = a0; n1 = a1; n2 = a2; n3 = a3;
        model_step(0, e); q_a.push_back(e);
        model_step(1, e); q_b.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_a();
        compare_b();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        int accepted;
        bit v;
        rst = 1'b1; st = 1'b0; in_valid = 1'b0;
        n0 = '0; n1 = '0; n2 = '0; n3 = '0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        @(negedge clk);
        chk("reset.pm0", 32'(b_pm0), 0);
        chk("reset.dec_valid", 32'(b_dv), 0);
        rst = 1'b0;

        // In IDLE an unstarted symbol is ignored.
        step(1'b0, 1'b1, 4'h5, 4'h5, 4'h5, 4'h5);

        // Symbol 00 then symbol 11 from the start metrics.
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b1000, 4'b0101, 4'b0010, 4'b0101);
        chk("sym00.pm", {b_pm0, b_pm1, b_pm2, b_pm3}, {6'd0, 6'd9, 6'd2, 6'd9});
        chk("sym00.decision", 32'(b_dec), 32'h0);
        step(1'b0, 1'b1, 4'b0010, 4'b0101, 4'b1000, 4'b0101);
        chk("sym11.pm", {b_pm0, b_pm1, b_pm2, b_pm3}, {6'd2, 6'd3, 6'd0, 6'd3});
        chk("sym11.decision", 32'(b_dec), 32'h0);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_async.pm", {b_pm0, b_pm1, b_pm2, b_pm3}, 0);
        chk("rst_async.pmA", {a_pm0, a_pm1, a_pm2, a_pm3}, 0);
        chk("rst_async.dec", {a_dec, b_dec}, 0);
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 4'h5, 4'h5, 4'h5, 4'h5);

        // Drive metrics to all-equal, then a symmetric symbol exercises the tie rule.
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b0011, 4'b0011, 4'b0011, 4'b0011);
        step(1'b0, 1'b1, 4'b0011, 4'b0011, 4'b0011, 4'b0011);
        step(1'b0, 1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b0101);
        chk("tie.pm", {b_pm0, b_pm1, b_pm2, b_pm3}, {6'd7, 6'd7, 6'd7, 6'd7});
        chk("tie.decision", 32'(b_dec), 32'h0);

        // Short frame with idle gaps, then a fifth symbol after done.
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b1001, 4'b0110, 4'b0011, 4'b1100);
        idle();
        step(1'b0, 1'b1, 4'b0111, 4'b1101, 4'b0010, 4'b1000);
        idle();
        idle();
        step(1'b0, 1'b1, 4'b1110, 4'b0001, 4'b1011, 4'b0100);
        step(1'b0, 1'b1, 4'b0010, 4'b1111, 4'b0110, 4'b1001);
        chk("frame.done", 32'(b_done), 1);
        step(1'b0, 1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b0101);
        chk("frame.after_done", 32'(b_dv), 0);

        // Start coinciding with what would be the last symbol: start wins.
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int s = 0; s < 3; s++)
            step(1'b0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        step(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        chk("st_wins.done", 32'(b_done), 0);
        for (int s = 0; s < 4; s++)
            step(1'b0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

        // Long random run forcing repeated normalisation on the narrow instance.
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        accepted = 0;
        while (accepted < 200) begin
            v = ($urandom_range(0, 5) != 0);
            step(1'b0, v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if (v) accepted++;
        end
        chk("norm.occurred", 32'(moff[0] > 0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
